// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-drain UART transmitter:
// FSM state encodings and serial line levels.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the UART transmitter. Counts 0..CLKS_PER_BIT-1
// while not cleared; o_tick marks the last cycle of a bit period and
// o_pre_tick the cycle before it.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick,
  output logic o_pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] r_count;

  // Free-running bit-period counter, held at zero while cleared.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_tick     = !i_clear && (r_count == LAST);
  assign o_pre_tick = !i_clear && (r_count == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drain stage for a synchronous FIFO: pops one byte at a time and sends it
// as an async UART frame (start, data LSB first, optional parity, stop).
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even-parity bit.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
  input  logic                  i_tx_enable,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_bit_idx;
  logic                  r_tx;
  logic                  r_rd_en;
  logic                  r_busy;
  logic                  r_done;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  r_parity;
`endif

  logic w_baud_clr;
  logic w_tick;
  logic w_pre_tick;
  logic w_last_stop;

  // The bit timer only runs once a byte is loaded and a bit is on the line.
  assign w_baud_clr  = (r_state == S_IDLE) || (r_state == S_FETCH) || (r_state == S_LOAD);
  assign w_last_stop = (r_state == S_STOP) && (r_bit_idx == LAST_STOP);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_baud_clr),
    .o_tick    (w_tick),
    .o_pre_tick(w_pre_tick)
  );

  // Frame sequencer: pop handshake, shift register and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register is reset as well so no stale payload survives a mid-frame reset.
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= LINE_IDLE;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= LINE_IDLE;
          if (i_tx_enable && !i_fifo_empty) begin
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          // The FIFO pops on this edge; its data is valid during LOAD.
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_shift  <= i_fifo_rdata;
`ifdef FIFO_UART_TX_PARITY_EN
          r_parity <= ^i_fifo_rdata;
`endif
          r_tx     <= START_BIT;
          r_state  <= S_START;
        end
        S_START: begin
          if (w_tick) begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_DATA) begin
              r_bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              r_tx      <= r_parity;
              r_state   <= S_PARITY;
`else
              r_tx      <= LINE_IDLE;
              r_state   <= S_STOP;
`endif
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + BW'(1);
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_tx      <= LINE_IDLE;
            r_bit_idx <= '0;
            r_state   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          // frame_done is registered, so raise it one cycle ahead of the final tick.
          if (w_last_stop && w_pre_tick) begin
            r_done <= 1'b1;
          end
          if (w_tick) begin
            if (w_last_stop) begin
              r_busy    <= 1'b0;
              r_bit_idx <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_bit_idx <= r_bit_idx + BW'(1);
            end
          end
        end
        default: begin
          r_tx    <= LINE_IDLE;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_tx         = r_tx;
  assign o_fifo_rd_en = r_rd_en;
  assign o_busy       = r_busy;
  assign o_frame_done = r_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx (DATA_WIDTH=8, CLKS_PER_BIT=4,
// STOP_BITS=1) with a 16-deep FIFO model on its read port.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty;
  logic          rd_en;
  logic [DW-1:0] rdata;
  logic          tx_enable = 1'b0;
  logic          tx;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_fifo_empty(fifo_empty),
    .o_fifo_rd_en(rd_en),
    .i_fifo_rdata(rdata),
    .i_tx_enable (tx_enable),
    .o_tx        (tx),
    .o_busy      (busy),
    .o_frame_done(done)
  );

  // FIFO model: combinational empty, registered read data.
  logic [DW-1:0] mem [16];
  logic [4:0]    wp = '0;
  logic [4:0]    rp = '0;
  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (rd_en && (wp != rp)) begin
      rdata <= mem[rp[3:0]];
      rp    <= rp + 5'd1;
    end
  end

  // Read-strobe monitor: pulse count and back-to-back strobe detection.
  int   rd_pulses = 0;
  int   rd_double = 0;
  logic prev_rd = 1'b0;
  always @(posedge clk) begin
    if (rd_en) rd_pulses <= rd_pulses + 1;
    if (rd_en && prev_rd) rd_double <= rd_double + 1;
    prev_rd <= rd_en;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One frame vector: payload, hand-computed line bits (bit i = i-th bit
  // period: start, d0..d7, stop) and hand-computed even parity.
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wp[3:0]] = d;
    wp = wp + 5'd1;
  endtask

  function automatic logic exp_bit(input vec_t v, input int b);
`ifdef FIFO_UART_TX_PARITY_EN
    if (b < 9)  return v.frame[b];
    if (b == 9) return v.par;
    return 1'b1;
`else
    return v.frame[b];
`endif
  endfunction

  // Advance until the start bit appears; gap = tx-high cycles seen on the way.
  task automatic wait_start(output int gap);
    gap = 0;
    step();
    while (tx === 1'b1 && gap < 100) begin
      gap++;
      step();
    end
    if (gap >= 100) check("start_timeout", tx, 0);
  endtask

  // Check a whole frame from its first start-bit cycle; ends on the last cycle.
  task automatic capture(input vec_t v, input int drop_at);
    for (int i = 0; i < FLEN; i++) begin
      if (i == drop_at) tx_enable = 1'b0;
      check($sformatf("tx_%02h_c%0d", v.data, i), tx, exp_bit(v, i / CPB));
      check($sformatf("busy_%02h_c%0d", v.data, i), busy, 1);
      check($sformatf("done_%02h_c%0d", v.data, i), done, (i == FLEN - 1) ? 1 : 0);
      if (i < FLEN - 1) step();
    end
  endtask

  initial begin
    int gap;
    int base;

    vecs[0] = '{data: 8'hA5, frame: 10'h34A, par: 1'b0};
    vecs[1] = '{data: 8'h00, frame: 10'h200, par: 1'b0};
    vecs[2] = '{data: 8'hFF, frame: 10'h3FE, par: 1'b0};
    vecs[3] = '{data: 8'h3C, frame: 10'h278, par: 1'b0};
    vecs[4] = '{data: 8'h07, frame: 10'h20E, par: 1'b1};

    // 1: reset held for three cycles
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_tx", tx, 1);
      check("rst_rd_en", rd_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    rst = 1'b0;
    step();
    check("idle_tx", tx, 1);

    // 2: single byte 0xA5
    base = rd_pulses;
    push(8'hA5);
    tx_enable = 1'b1;
    wait_start(gap);
    capture(vecs[0], -1);
    step();
    check("t2_busy_after", busy, 0);
    check("t2_rd_pulses", rd_pulses - base, 1);
    check("t2_empty", fifo_empty, 1);

    // 3: back-to-back 0x00, 0xFF
    base = rd_pulses;
    push(8'h00);
    push(8'hFF);
    wait_start(gap);
    capture(vecs[1], -1);
    wait_start(gap);
    check("t3_gap", gap, 3);
    capture(vecs[2], -1);
    step();
    check("t3_rd_pulses", rd_pulses - base, 2);
    check("t3_empty", fifo_empty, 1);
    check("t3_busy_after", busy, 0);

    // 4: tx_enable dropped during the first frame's data bits
    base = rd_pulses;
    push(8'h3C);
    push(8'h07);
    push(8'hA5);
    wait_start(gap);
    capture(vecs[3], 8);
    repeat (10) step();
    check("t4_rd_pulses", rd_pulses - base, 1);
    check("t4_level", 32'(wp - rp), 2);
    check("t4_busy", busy, 0);
    check("t4_tx", tx, 1);

    // 5: resume; 0x07 exercises the parity bit and frame length
    base = rd_pulses;
    tx_enable = 1'b1;
    wait_start(gap);
    capture(vecs[4], -1);
    wait_start(gap);
    check("t5_gap", gap, 3);
    capture(vecs[0], -1);
    step();
    check("t5_rd_pulses", rd_pulses - base, 2);
    check("t5_empty", fifo_empty, 1);

    // 6: reset during data bit 3; the popped byte is dropped
    base = rd_pulses;
    push(8'h3C);
    push(8'hFF);
    wait_start(gap);
    repeat (16) step();
    check("t6_pre_rst_tx", tx, 1);
    check("t6_pre_rst_busy", busy, 1);
    rst = 1'b1;
    step();
    check("t6_rst_tx", tx, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_rd_en", rd_en, 0);
    rst = 1'b0;
    wait_start(gap);
    capture(vecs[2], -1);
    step();
    check("t6_rd_pulses", rd_pulses - base, 2);
    check("t6_empty", fifo_empty, 1);
    check("t6_busy_after", busy, 0);

    check("rd_single_cycle", rd_double, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
